rob_reorder_buffer: RTL and testbench

- Reorder buffer. Hands out tags in program order, accepts completions in any order, and retires results strictly in tag-allocation order.
- Sits between the request issue stage (allocate side) and the in-order response consumer (valid/ready retire side).
- Storage is a circular pointer pair, wrapping like the team's FIFO, plus a per-entry done flag.

---
 rtl/rob_reorder_buffer.sv | 149 ++++++++++++++
 tb/tb_rob_reorder_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_reorder_buffer.sv
// Reorder buffer: in-order tag allocation, out-of-order completion, in-order retire.
// Define ROB_HEAD_BYPASS_EN to forward a completion to the head straight to the retire port.
module rob_reorder_buffer #(
   parameter int width = 8,
   parameter int depth = 4,
   localparam int tag_width = $clog2(depth),
   localparam int count_width = $clog2(depth + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alloc_req,
   output logic                   alloc_gnt,
   output logic [tag_width-1:0]   alloc_tag,
   input  logic                   cpl_valid,
   input  logic [tag_width-1:0]   cpl_tag,
   input  logic [width-1:0]       cpl_data,
   output logic                   cpl_err,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [width-1:0]       out_data,
   output logic [tag_width-1:0]   out_tag,
   output logic                   empty,
   output logic                   full,
   output logic [count_width-1:0] count
);

   localparam logic [tag_width:0]     depth_ext  = (tag_width + 1)'(depth);
   localparam logic [tag_width-1:0]   last_ptr   = tag_width'(depth - 1);
   localparam logic [count_width-1:0] full_count = count_width'(depth);

   logic [tag_width-1:0]   wr_ptr_r;
   logic [tag_width-1:0]   rd_ptr_r;
   logic [count_width-1:0] count_r;
   logic [count_width-1:0] count_nxt_s;
   logic                   empty_r;
   logic                   full_r;
   logic                   cpl_err_r;
   logic [depth-1:0]       alloc_r;
   logic [depth-1:0]       done_r;
   logic [width-1:0]       data_r [depth];

   logic                   alloc_gnt_s;
   logic                   cpl_legal_s;
   logic                   head_done_s;
   logic                   retire_s;
   logic                   out_valid_s;
   logic [width-1:0]       out_data_s;

   // Pointers wrap at depth-1 so non-power-of-two depths work.
   function automatic logic [tag_width-1:0] ptr_inc(input logic [tag_width-1:0] ptr);
      logic [tag_width-1:0] nxt;
      if (ptr == last_ptr) begin
         nxt = '0;
      end else begin
         nxt = ptr + tag_width'(1);
      end
      return nxt;
   endfunction

   assign alloc_gnt_s = alloc_req && !full_r;

   // A completion is legal only for an in-range, allocated, not-yet-done tag.
   always_comb begin
      cpl_legal_s = 1'b0;
      if (cpl_valid && ({1'b0, cpl_tag} < depth_ext)) begin
         cpl_legal_s = alloc_r[cpl_tag] && !done_r[cpl_tag];
      end else begin
         cpl_legal_s = 1'b0;
      end
   end

   // Head presentation; the bypass build adds a same-cycle forward of a head completion.
   always_comb begin
      head_done_s = !empty_r && done_r[rd_ptr_r];
`ifdef ROB_HEAD_BYPASS_EN
      if (cpl_legal_s && (cpl_tag == rd_ptr_r)) begin
         out_valid_s = 1'b1;
         out_data_s  = cpl_data;
      end else begin
         out_valid_s = head_done_s;
         out_data_s  = data_r[rd_ptr_r];
      end
`else
      out_valid_s = head_done_s;
      out_data_s  = data_r[rd_ptr_r];
`endif
      retire_s = out_valid_s && out_ready;
   end

   // Occupancy tracking: simultaneous alloc and retire cancel out.
   always_comb begin
      count_nxt_s = count_r;
      case ({alloc_gnt_s, retire_s})
         2'b10:   count_nxt_s = count_r + count_width'(1);
         2'b01:   count_nxt_s = count_r - count_width'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Control state; retire clears last so a bypassed head never leaves done set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         empty_r   <= 1'b1;
         full_r    <= 1'b0;
         cpl_err_r <= 1'b0;
         alloc_r   <= '0;
         done_r    <= '0;
      end else begin
         cpl_err_r <= cpl_valid && !cpl_legal_s;
         if (alloc_gnt_s) begin
            alloc_r[wr_ptr_r] <= 1'b1;
            done_r[wr_ptr_r]  <= 1'b0;
            wr_ptr_r          <= ptr_inc(wr_ptr_r);
         end
         if (cpl_legal_s) begin
            done_r[cpl_tag] <= 1'b1;
         end
         if (retire_s) begin
            alloc_r[rd_ptr_r] <= 1'b0;
            done_r[rd_ptr_r]  <= 1'b0;
            rd_ptr_r          <= ptr_inc(rd_ptr_r);
         end
         count_r <= count_nxt_s;
         empty_r <= (count_nxt_s == '0);
         full_r  <= (count_nxt_s == full_count);
      end
   end

   // Result storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (rst_n && cpl_legal_s) begin
         data_r[cpl_tag] <= cpl_data;
      end
   end

   assign alloc_gnt = alloc_gnt_s;
   assign alloc_tag = wr_ptr_r;
   assign cpl_err   = cpl_err_r;
   assign out_valid = out_valid_s;
   assign out_data  = out_data_s;
   assign out_tag   = rd_ptr_r;
   assign empty     = empty_r;
   assign full      = full_r;
   assign count     = count_r;

endmodule

// File: tb/tb_rob_reorder_buffer.sv
// Self-checking bench for rob_reorder_buffer (depth=4, width=8) with an in-order retire scoreboard.
module tb_rob_reorder_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       alloc_req;
   logic       alloc_gnt;
   logic [1:0] alloc_tag;
   logic       cpl_valid;
   logic [1:0] cpl_tag;
   logic [7:0] cpl_data;
   logic       cpl_err;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_tag;
   logic       empty;
   logic       full;
   logic [2:0] count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Scoreboard: tags in allocation order, plus the result each tag must retire with.
   logic [1:0] ord_q[$];
   logic [7:0] exp_data [4];

   rob_reorder_buffer #(.width(8), .depth(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data), .cpl_err(cpl_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .empty(empty), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a completion sequence and pops/compares every retirement seen on the way.
   task automatic complete_and_drain(input logic [1:0] tags [4], input logic [7:0] dat [4], input int cycles);
      out_ready = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         if (c < 4) begin
            cpl_valid = 1'b1; cpl_tag = tags[c]; cpl_data = dat[c];
            exp_data[tags[c]] = dat[c];
         end else begin
            cpl_valid = 1'b0;
         end
         #1;
         if (out_valid) begin
            n_cmp++;
            if (ord_q.size() == 0) begin
               n_fail++; $display("FAIL retire_unexpected tag=%0d", out_tag);
            end else begin
               if (out_tag !== ord_q[0] || out_data !== exp_data[ord_q[0]]) begin
                  n_fail++;
                  $display("FAIL retire_order got tag=%0d data=%h want tag=%0d data=%h",
                           out_tag, out_data, ord_q[0], exp_data[ord_q[0]]);
               end
               void'(ord_q.pop_front());
            end
         end
         tick();
      end
      cpl_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (ord_q.size() != 0 || empty !== 1'b1 || count !== 3'd0) begin
         n_fail++; $display("FAIL drain_empty got left=%0d empty=%b count=%0d want 0 1 0", ord_q.size(), empty, count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; alloc_req = 1'b0; cpl_valid = 1'b0; cpl_tag = 2'd0; cpl_data = 8'h00; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || cpl_err !== 1'b0 || alloc_tag !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state got count=%0d empty=%b full=%b ov=%b err=%b tag=%0d want 0 1 0 0 0 0",
                  count, empty, full, out_valid, cpl_err, alloc_tag);
      end
      tick();
   endtask

   task automatic test_alloc_full();
      alloc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (alloc_gnt !== 1'b1 || alloc_tag !== 2'(i)) begin
            n_fail++; $display("FAIL alloc_tag got gnt=%b tag=%0d want 1 %0d", alloc_gnt, alloc_tag, i);
         end
         ord_q.push_back(2'(i));
         tick();
      end
      #1;
      n_cmp++;
      if (full !== 1'b1 || count !== 3'd4 || empty !== 1'b0) begin
         n_fail++; $display("FAIL full_flags got full=%b count=%0d empty=%b want 1 4 0", full, count, empty);
      end
      n_cmp++;
      if (alloc_gnt !== 1'b0) begin
         n_fail++; $display("FAIL gnt_when_full got %b want 0", alloc_gnt);
      end
      tick();
      alloc_req = 1'b0;
   endtask

   task automatic test_out_of_order();
      logic [1:0] tags [4];
      logic [7:0] dat [4];
      tags = '{2'd2, 2'd0, 2'd3, 2'd1};
      dat  = '{8'h22, 8'h00, 8'h33, 8'h11};
      complete_and_drain(tags, dat, 10);
   endtask

   task automatic test_full_retire();
      logic [1:0] tags [4];
      logic [7:0] dat [4];
      alloc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ord_q.push_back(2'(i));
         tick();
      end
      alloc_req = 1'b0;
      cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_data = 8'hA0; exp_data[0] = 8'hA0;
      tick();
      cpl_valid = 1'b0;
      alloc_req = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (alloc_gnt !== 1'b0) begin
         n_fail++; $display("FAIL gnt_in_retire_cycle got %b want 0", alloc_gnt);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_tag !== ord_q[0] || out_data !== exp_data[ord_q[0]]) begin
         n_fail++; $display("FAIL full_retire got ov=%b tag=%0d data=%h want 1 %0d %h",
                            out_valid, out_tag, out_data, ord_q[0], exp_data[ord_q[0]]);
      end
      void'(ord_q.pop_front());
      tick();
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd0) begin
         n_fail++; $display("FAIL wrap_grant got gnt=%b tag=%0d want 1 0", alloc_gnt, alloc_tag);
      end
      ord_q.push_back(2'd0);
      tick();
      alloc_req = 1'b0;
      #1;
      n_cmp++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_fail++; $display("FAIL wrap_count got count=%0d full=%b want 4 1", count, full);
      end
      tags = '{2'd1, 2'd2, 2'd3, 2'd0};
      dat  = '{8'hB1, 8'hB2, 8'hB3, 8'hB0};
      complete_and_drain(tags, dat, 8);
   endtask

   task automatic test_cpl_err();
      alloc_req = 1'b1;
      #1;
      n_cmp++;
      if (alloc_tag !== 2'd1) begin
         n_fail++; $display("FAIL err_alloc_tag got %0d want 1", alloc_tag);
      end
      ord_q.push_back(2'd1); tick();
      ord_q.push_back(2'd2); tick();
      alloc_req = 1'b0; out_ready = 1'b0;
      cpl_valid = 1'b1; cpl_tag = 2'd1; cpl_data = 8'h11; exp_data[1] = 8'h11;
      tick();
      cpl_valid = 1'b0;
      #1;
      n_cmp++;
      if (cpl_err !== 1'b0) begin
         n_fail++; $display("FAIL err_legal got %b want 0", cpl_err);
      end
      cpl_valid = 1'b1; cpl_tag = 2'd1; cpl_data = 8'hEE;
      tick();
      cpl_valid = 1'b0;
      #1;
      n_cmp++;
      if (cpl_err !== 1'b1) begin
         n_fail++; $display("FAIL err_dup got %b want 1", cpl_err);
      end
      tick();
      n_cmp++;
      if (cpl_err !== 1'b0) begin
         n_fail++; $display("FAIL err_dup_pulse got %b want 0", cpl_err);
      end
      cpl_valid = 1'b1; cpl_tag = 2'd3; cpl_data = 8'h77;
      tick();
      cpl_valid = 1'b0;
      #1;
      n_cmp++;
      if (cpl_err !== 1'b1) begin
         n_fail++; $display("FAIL err_unalloc got %b want 1", cpl_err);
      end
      tick();
      n_cmp++;
      if (cpl_err !== 1'b0 || count !== 3'd2) begin
         n_fail++; $display("FAIL err_unalloc_pulse got err=%b count=%0d want 0 2", cpl_err, count);
      end
   endtask

   task automatic test_hold();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== exp_data[1]) begin
            n_fail++; $display("FAIL hold_stable got ov=%b tag=%0d data=%h want 1 1 %h", out_valid, out_tag, out_data, exp_data[1]);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_tag !== ord_q[0] || out_data !== exp_data[ord_q[0]]) begin
         n_fail++; $display("FAIL hold_retire got ov=%b tag=%0d data=%h want 1 %0d %h",
                            out_valid, out_tag, out_data, ord_q[0], exp_data[ord_q[0]]);
      end
      void'(ord_q.pop_front());
      tick();
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || count !== 3'd1 || out_tag !== 2'd2) begin
         n_fail++; $display("FAIL hold_once got ov=%b count=%0d tag=%0d want 0 1 2", out_valid, count, out_tag);
      end
   endtask

   task automatic test_midreset();
      alloc_req = 1'b1;
      tick(); tick();
      alloc_req = 1'b0;
      cpl_valid = 1'b1; cpl_tag = 2'd3; cpl_data = 8'h33;
      tick();
      rst_n = 1'b0; alloc_req = 1'b1; cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_data = 8'h99;
      tick();
      rst_n = 1'b1; alloc_req = 1'b0; cpl_valid = 1'b0;
      ord_q.delete();
      #1;
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || alloc_tag !== 2'd0 || cpl_err !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_state got count=%0d empty=%b full=%b ov=%b tag=%0d err=%b want 0 1 0 0 0 0",
                  count, empty, full, out_valid, alloc_tag, cpl_err);
      end
      alloc_req = 1'b1;
      #1;
      n_cmp++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd0) begin
         n_fail++; $display("FAIL midreset_alloc got gnt=%b tag=%0d want 1 0", alloc_gnt, alloc_tag);
      end
      ord_q.push_back(2'd0);
      tick();
      alloc_req = 1'b0;
      #1;
      n_cmp++;
      if (count !== 3'd1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_after got count=%0d ov=%b want 1 0", count, out_valid);
      end
   endtask

   task automatic test_head_bypass();
      cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_data = 8'h5A; exp_data[0] = 8'h5A; out_ready = 1'b1;
      #1;
`ifdef ROB_HEAD_BYPASS_EN
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
         n_fail++; $display("FAIL bypass_same_cycle got ov=%b data=%h want 1 5a", out_valid, out_data);
      end
      void'(ord_q.pop_front());
      tick();
      cpl_valid = 1'b0;
`else
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL no_bypass_same_cycle got ov=%b want 0", out_valid);
      end
      tick();
      cpl_valid = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_data[ord_q[0]] || out_tag !== ord_q[0]) begin
         n_fail++; $display("FAIL head_next_cycle got ov=%b data=%h tag=%0d want 1 5a 0", out_valid, out_data, out_tag);
      end
      void'(ord_q.pop_front());
      tick();
`endif
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL head_retired got count=%0d empty=%b ov=%b want 0 1 0", count, empty, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_alloc_full();
      test_out_of_order();
      test_full_retire();
      test_cpl_err();
      test_hold();
      test_midreset();
      test_head_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
